// File: rtl/key_sw_device_pkg.sv
// Shared definitions for the KEY/SW memory-mapped responder: register map,
// CTRL bit layout and the per-device status update rule.
package key_sw_device_pkg;

   localparam logic [31:0] ADDR_HEX   = 32'hFFFFF000;
   localparam logic [31:0] ADDR_LEDR  = 32'hFFFFF020;
   localparam logic [31:0] ADDR_KDATA = 32'hFFFFF080;
   localparam logic [31:0] ADDR_KCTRL = 32'hFFFFF084;
   localparam logic [31:0] ADDR_SDATA = 32'hFFFFF090;
   localparam logic [31:0] ADDR_SCTRL = 32'hFFFFF094;

   localparam int CTRL_READY   = 0;
   localparam int CTRL_OVERRUN = 1;
   localparam int CTRL_IE      = 4;

   typedef struct packed {
      logic ie;
      logic ovr;
      logic ready;
   } ctrl_t;

   // A load racing a DATA read leaves overrun alone (the read took the old
   // value); a load racing an overrun-clear write wins over the clear.
   function automatic ctrl_t ctrl_next(ctrl_t cur, logic load, logic data_rd,
                                       logic ctrl_wr, logic wr_ovr, logic wr_ie);
      ctrl_t n;
      n = cur;
      if (ctrl_wr) begin
         n.ie = wr_ie;
         if (!wr_ovr) n.ovr = 1'b0;
      end
      if (load && cur.ready && !data_rd) n.ovr = 1'b1;
      if (load)         n.ready = 1'b1;
      else if (data_rd) n.ready = 1'b0;
      return n;
   endfunction

   function automatic logic [7:0] ctrl_byte(ctrl_t c);
      logic [7:0] b;
      b = '0;
      b[CTRL_READY]   = c.ready;
      b[CTRL_OVERRUN] = c.ovr;
      b[CTRL_IE]      = c.ie;
      return b;
   endfunction

endpackage

// File: rtl/key_sw_device_if.sv
// Data-memory bus slice seen by the KEY/SW responder (MEM-stage loads/stores).
interface key_sw_device_if #(parameter int DBITS = 32);
   logic [DBITS-1:0] abus_in;
   logic             re_in;
   logic             we_in;
   logic [DBITS-1:0] wdata_in;
   logic [DBITS-1:0] dbus_out;
   logic             hit_out;

   modport master (output abus_in, re_in, we_in, wdata_in, input dbus_out, hit_out);
   modport slave  (input abus_in, re_in, we_in, wdata_in, output dbus_out, hit_out);
endinterface

// File: rtl/key_sw_device_io_debounce.sv
// Two-flop synchronizer, stable-sample counter and data register for one
// bank of board inputs; load_o is high in the cycle before the register loads.
module io_debounce #(
   parameter int               WIDTH           = 4,
   parameter int               DEBOUNCE_CYCLES = 50000,
   parameter logic [WIDTH-1:0] RST_VAL         = '0,
   parameter bit               INVERT          = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] raw_i,
   output logic [WIDTH-1:0] data_o,
   output logic             load_o
);
   localparam int            CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES);

   logic [WIDTH-1:0] sync1_q, sync2_q, last_q, data_q, data_d, s;
   logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;

   assign s = INVERT ? ~sync2_q : sync2_q;

   always_comb begin
      cnt_d   = '0;
      load_o  = 1'b0;
      data_d  = data_q;
      cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
      if (s != data_q) begin
         // A fresh or changed candidate value starts counting at one.
         cnt_d = (s != last_q || cnt_q == '0) ? CW'(1) : cnt_inc;
         if (cnt_d >= TC) begin
            load_o = 1'b1;
            data_d = s;
            cnt_d  = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= RST_VAL;
         sync2_q <= RST_VAL;
         last_q  <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         last_q  <= s;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   assign data_o = data_q;
endmodule

// File: rtl/key_sw_device.sv
// KEY/SW responder: two debounced input banks, their CTRL/status registers,
// address decode, zero-latency read mux and the interrupt request.
module key_sw_device
   import key_sw_device_pkg::*;
#(
   parameter int               DBITS           = 32,
   parameter int               DEBOUNCE_CYCLES = 50000,
   parameter logic [DBITS-1:0] ADDRKDATA       = DBITS'(ADDR_KDATA),
   parameter logic [DBITS-1:0] ADDRKCTRL       = DBITS'(ADDR_KCTRL),
   parameter logic [DBITS-1:0] ADDRSDATA       = DBITS'(ADDR_SDATA),
   parameter logic [DBITS-1:0] ADDRSCTRL       = DBITS'(ADDR_SCTRL)
) (
   input  logic             clk,
   input  logic             reset,
   key_sw_device_if.slave   bus,
   input  logic [3:0]       KEY,
   input  logic [9:0]       SW,
   output logic             intr_out
);
   logic [3:0] kdata;
   logic [9:0] sdata;
   logic       k_load, s_load;
   logic       sel_kd, sel_kc, sel_sd, sel_sc;
   ctrl_t      kctrl_q, kctrl_d, sctrl_q, sctrl_d;
   logic       unused_wdata;

   io_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                 .RST_VAL(4'hF), .INVERT(1'b1)) u_key_db (
      .clk(clk), .reset(reset), .raw_i(KEY), .data_o(kdata), .load_o(k_load));

   io_debounce #(.WIDTH(10), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                 .RST_VAL(10'h000), .INVERT(1'b0)) u_sw_db (
      .clk(clk), .reset(reset), .raw_i(SW), .data_o(sdata), .load_o(s_load));

   assign sel_kd      = (bus.abus_in == ADDRKDATA);
   assign sel_kc      = (bus.abus_in == ADDRKCTRL);
   assign sel_sd      = (bus.abus_in == ADDRSDATA);
   assign sel_sc      = (bus.abus_in == ADDRSCTRL);
   assign bus.hit_out = sel_kd | sel_kc | sel_sd | sel_sc;

   // Only bits 1 and 4 of store data matter.
   assign unused_wdata = ^bus.wdata_in;

   always_comb begin
      kctrl_d = ctrl_next(kctrl_q, k_load, bus.re_in & sel_kd, bus.we_in & sel_kc,
                          bus.wdata_in[CTRL_OVERRUN], bus.wdata_in[CTRL_IE]);
      sctrl_d = ctrl_next(sctrl_q, s_load, bus.re_in & sel_sd, bus.we_in & sel_sc,
                          bus.wdata_in[CTRL_OVERRUN], bus.wdata_in[CTRL_IE]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         kctrl_q <= '0;
         sctrl_q <= '0;
      end else begin
         kctrl_q <= kctrl_d;
         sctrl_q <= sctrl_d;
      end
   end

   always_comb begin
      bus.dbus_out = '0;
      if (sel_kd)      bus.dbus_out = DBITS'(kdata);
      else if (sel_kc) bus.dbus_out = DBITS'(ctrl_byte(kctrl_q));
      else if (sel_sd) bus.dbus_out = DBITS'(sdata);
      else if (sel_sc) bus.dbus_out = DBITS'(ctrl_byte(sctrl_q));
   end

   assign intr_out = (kctrl_q.ie & kctrl_q.ready) | (sctrl_q.ie & sctrl_q.ready);
endmodule
